ex_pkt_packer: RTL

Drains the 8-bit video/Ethernet payload data FIFO (`ex_data_fifo`, 2048 x 8, almost_full at 1460) one packet at a time. Emits a byte stream on a valid/ready interface toward the UDP TX stage. Each packet is a 4-byte header (magic + 16-bit sequence number) followed by exactly PAYLOAD_LEN payload bytes, then a fixed inter-packet gap. A packet starts only when the FIFO holds a full payload, so the stream never underruns mid-packet.

---
 rtl/ex_pkt_pkg.sv | 25 ++
 rtl/ex_skid_buf2.sv | 46 ++++
 rtl/ex_pkt_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ex_pkt_pkg.sv
// Shared types and constants for the packet packer: FSM states, header layout,
// and the header byte selector.
package ex_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  localparam logic [7:0] HDR_MAGIC0 = 8'hA5;
  localparam logic [7:0] HDR_MAGIC1 = 8'h5A;
  localparam int         HDR_LEN    = 4;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
    case (idx)
      2'd0:    return HDR_MAGIC0;
      2'd1:    return HDR_MAGIC1;
      2'd2:    return seq[15:8];
      default: return seq[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ex_skid_buf2.sv
// Two-entry byte FIFO that decouples the one-cycle FIFO read latency from
// downstream backpressure. Push while full is accepted only with a pop.
module ex_skid_buf2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [1:0] count,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // NOTE: the storage array has no reset; count_q gates every consumer, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/ex_pkt_packer.sv
// Packetizer: waits for a full payload in the data FIFO, then emits a 4-byte
// header and PAYLOAD_LEN payload bytes on a valid/ready stream, then an IPG.
module ex_pkt_packer
  import ex_pkt_pkg::*;
#(
  parameter int PAYLOAD_LEN = 1460,
  parameter int IPG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_rd_empty,
  input  logic        fifo_almost_full,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic [15:0] pkt_seq,
  output logic        underflow_err
);

  localparam int            CW      = $clog2(PAYLOAD_LEN + 1);
  localparam int            GW      = $clog2(IPG_CYCLES + 1);
  localparam logic [CW-1:0] LEN_C   = CW'(PAYLOAD_LEN);
  localparam logic [CW-1:0] LAST_C  = CW'(PAYLOAD_LEN - 1);
  localparam logic [1:0]    HDR_END = 2'(HDR_LEN - 1);
  // GAP holds IPG_CYCLES-1 cycles; the IDLE cycle that samples almost_full completes the gap.
  localparam logic [GW-1:0] GAP_END = GW'(IPG_CYCLES - 2);

  state_t        state_q, state_d;
  logic [1:0]    hdr_idx_q;
  logic [CW-1:0] rd_cnt_q;
  logic [CW-1:0] tx_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          inflight_q;
  logic [15:0]   pkt_seq_q;
  logic [15:0]   pkt_seq_d;
  logic          underflow_q;

  logic          in_payload;
  logic          rd_owed;
  logic          last_hs;
  logic          sk_pop;
  logic          sk_empty;
  logic [1:0]    sk_count;
  logic [7:0]    sk_dout;
  logic [1:0]    occ;

  ex_skid_buf2 u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (fifo_rd_data),
    .pop   (sk_pop),
    .dout  (sk_dout),
    .count (sk_count),
    .empty (sk_empty)
  );

  assign in_payload = (state_q == ST_PAYLOAD);
  assign rd_owed    = in_payload && (rd_cnt_q < LEN_C);
  assign sk_pop     = in_payload && !sk_empty && tx_ready;

  // The slot freed by this cycle's pop counts as free, which is what sustains 1 byte/cycle.
  assign occ        = sk_count - 2'(sk_pop) + 2'(inflight_q);
  assign fifo_rd_en = rd_owed && !fifo_rd_empty && (occ < 2'd2);

  assign tx_last   = in_payload && !sk_empty && (tx_cnt_q == LAST_C);
  assign last_hs   = tx_last && tx_ready;
  assign pkt_seq_d = pkt_seq_q + 16'(last_hs);

  assign pkt_seq       = pkt_seq_q;
  assign underflow_err = underflow_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_IDLE: if (fifo_almost_full) state_d = ST_HDR;
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(hdr_idx_q, pkt_seq_q);
        if (tx_ready && (hdr_idx_q == HDR_END)) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_valid = !sk_empty;
        if (!sk_empty) tx_data = sk_dout;
        if (last_hs) state_d = ST_GAP;
      end
      ST_GAP:  if (gap_cnt_q == GAP_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= '0;
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      pkt_seq_q   <= 16'h0000;
      underflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      pkt_seq_q  <= pkt_seq_d;
      if (rd_owed && fifo_rd_empty) underflow_q <= 1'b1;
      case (state_q)
        ST_HDR: if (tx_ready) hdr_idx_q <= hdr_idx_q + 2'd1;
        ST_PAYLOAD: begin
          if (fifo_rd_en)         rd_cnt_q <= rd_cnt_q + 1'b1;
          if (sk_pop)             tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        ST_GAP:  gap_cnt_q <= gap_cnt_q + 1'b1;
        default: ;
      endcase
      // Counters restart on every state change so each state begins from zero.
      if (state_d != state_q) begin
        hdr_idx_q <= '0;
        rd_cnt_q  <= '0;
        tx_cnt_q  <= '0;
        gap_cnt_q <= '0;
      end
    end
  end

endmodule
